// File: rtl/adder_pkg.sv
// ============================================================================
// Module   : adder_pkg
// Desc     : Shared state encoding, default width and counter sizing for the
//            bit-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit counter must index 0..WIDTH-1; keep at least one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_bit_slice.sv
// ============================================================================
// Module   : serial_bit_slice
// Desc     : Single full adder plus carry register with load and enable.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_slice (
  input  logic clk,
  input  logic reset_n,
  input  logic a,
  input  logic b,
  input  logic load,
  input  logic load_val,
  input  logic en,
  output logic s,
  output logic co,
  output logic carry
);

  logic r_carry;

  always_comb begin
    s  = a ^ b ^ r_carry;
    co = (a & b) | (a & r_carry) | (b & r_carry);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_carry <= 1'b0;
    end else if (load) begin
      r_carry <= load_val;
    end else if (en) begin
      r_carry <= co;
    end
  end

  assign carry = r_carry;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Desc     : Bit-serial WIDTH-bit adder, LSB first, one bit per clock, with
//            valid/ready handshakes on operand and result sides.
//            Optional macro SERIAL_ADDER_SUBTRACT_EN adds a 'sub' port (a - b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_b_load;
  logic [WIDTH-1:0] w_b_init;
  logic             w_c_init;
  logic             w_load;
  logic             w_en;
  logic             w_last;
  logic             w_s;
  logic             w_co;
  logic             w_carry;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  // Two's-complement subtract: a + ~b + 1.
  assign w_b_init = sub ? ~b : b;
  assign w_c_init = sub ? 1'b1 : cin;
`else
  assign w_b_init = b;
  assign w_c_init = cin;
`endif

  assign w_b_load = (r_state == IDLE) && in_valid;
  assign w_load   = w_b_load;
  assign w_en     = (r_state == RUN);
  assign w_last   = (r_count == c_last);

  serial_bit_slice u_slice (
    .clk      (clk),
    .reset_n  (reset_n),
    .a        (r_a_sr[0]),
    .b        (r_b_sr[0]),
    .load     (w_load),
    .load_val (w_c_init),
    .en       (w_en),
    .s        (w_s),
    .co       (w_co),
    .carry    (w_carry)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_b_load) begin
        r_a_sr  <= a;
        r_b_sr  <= w_b_init;
        r_count <= '0;
      end else if (w_en) begin
        r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
        r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
        r_sum   <= {w_s, r_sum[WIDTH-1:1]};
        r_count <= r_count + 1'b1;
        // On the MSB, carry-in vs carry-out of that bit gives signed overflow.
        if (w_last) begin
          r_cout <= w_co;
          r_ovf  <= w_carry ^ w_co;
        end
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Desc     : Directed, table-driven bench for serial_adder (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_checks = 0;
  int n_errors = 0;

  vec_t vecs[7];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check("in_ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input vec_t v, input string name);
    wait_ready();
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({name, "_busy"}, {31'd0, in_ready}, 32'd0);
    repeat (W - 1) step();
    check({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
    step();
    check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({name, "_sum"}, {24'd0, sum}, {24'd0, v.s});
    check({name, "_cout"}, {31'd0, cout}, {31'd0, v.co});
    check({name, "_ovf"}, {31'd0, overflow}, {31'd0, v.ov});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_idle"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vecs[0] = '{a: 8'h7F, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h80, co: 1'b0, ov: 1'b1};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sub: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[2] = '{a: 8'h00, b: 8'h00, cin: 1'b1, sub: 1'b0, s: 8'h01, co: 1'b0, ov: 1'b0};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sub: 1'b0, s: 8'h46, co: 1'b0, ov: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sub: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b1};
    vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b1, sub: 1'b0, s: 8'h00, co: 1'b1, ov: 1'b0};
    vecs[6] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sub: 1'b0, s: 8'hFF, co: 1'b1, ov: 1'b0};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: DONE holds under out_ready=0 and ignores in_valid.
    wait_ready();
    a = 8'h11; b = 8'h22; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (W) step();
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_sum", {24'd0, sum}, 32'h33);
    a = 8'h01; b = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_sum", {24'd0, sum}, 32'h33);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_ready", {31'd0, in_ready}, 32'd1);
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_sum", {24'd0, sum}, 32'h33);
    step();
    in_valid = 1'b0;
    check("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    repeat (W) step();
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_sum", {24'd0, sum}, 32'h02);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Reset mid-RUN at count=3.
    wait_ready();
    a = 8'hFF; b = 8'hFF; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    step();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {24'd0, sum}, 32'd0);
    check("midrst_cout", {31'd0, cout}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      step();
      check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    do_op(vecs[3], "post_rst");

    // Operand change during RUN must not affect the result.
    wait_ready();
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 8'hAA; b = 8'h55; cin = 1'b1;
    repeat (W) step();
    check("chg_valid", {31'd0, out_valid}, 32'd1);
    check("chg_sum", {24'd0, sum}, 32'h10);
    check("chg_cout", {31'd0, cout}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

`ifdef SERIAL_ADDER_SUBTRACT_EN
    do_op('{a: 8'h05, b: 8'h07, cin: 1'b0, sub: 1'b1, s: 8'hFE, co: 1'b0, ov: 1'b0}, "sub0");
    do_op('{a: 8'h80, b: 8'h01, cin: 1'b0, sub: 1'b1, s: 8'h7F, co: 1'b1, ov: 1'b1}, "sub1");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
